elvds_tx_framer: RTL and testbench

//  Upstream stage for an ELVDS_TBUF differential tristate output.

---
 rtl/elvds_tx_framer_if.sv | 19 +
 rtl/elvds_tx_framer.sv | 150 +++++++++++++++
 tb/tb_elvds_tx_framer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/elvds_tx_framer_if.sv
// ---------------------------------------------------------------------------
// elvds_tx_framer_if
//  Word handshake between a producer and the ELVDS transmit framer.
//  Signals:
//   in_data   word to send, sampled only when accepted
//   in_valid  producer has a word
//   in_ready  framer can take a word (accept = in_valid & in_ready)
//  Modports: master = producer side, slave = framer side.
// ---------------------------------------------------------------------------
interface elvds_tx_framer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/elvds_tx_framer.sv
// ---------------------------------------------------------------------------
// elvds_tx_framer
//  Feeds an ELVDS_TBUF differential tristate buffer. Takes words over a
//  valid/ready handshake, frames them (preamble, start, LSB-first data,
//  optional parity, stop) and serializes each bit for DIV clocks. The pins
//  are only driven while a frame is on the wire.
//  Ports:
//   clk_i     clock, all logic on posedge
//   rst_i     synchronous active-high reset
//   up        elvds_tx_framer_if.slave word handshake
//   tx_i_o    serial bit to ELVDS_TBUF.I (registered)
//   tx_oen_o  ELVDS_TBUF.OEN, 0 = drive, 1 = high-Z (registered)
//   busy_o    frame in progress
//  Build option: define ELVDS_TX_PARITY_EN to insert an even-parity bit
//  between the data and the stop bit.
// ---------------------------------------------------------------------------
module elvds_tx_framer #(
   parameter int DATA_W        = 8,
   parameter int DIV           = 4,
   parameter int PREAMBLE_BITS = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   elvds_tx_framer_if.slave  up,
   output logic              tx_i_o,
   output logic              tx_oen_o,
   output logic              busy_o
);
   localparam int MAXB  = (DATA_W > PREAMBLE_BITS) ? DATA_W : PREAMBLE_BITS;
   localparam int BIT_W = $clog2(MAXB + 1);
   localparam int DIV_W = $clog2(DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'(PREAMBLE_BITS - 1);
   localparam logic [BIT_W-1:0] DAT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, PRE, START, DATA, PAR, STOP} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] sr_q;
   logic [DIV_W-1:0]  div_q;
   logic [BIT_W-1:0]  bit_q;
   logic              tx_i_q, tx_oen_q;
`ifdef ELVDS_TX_PARITY_EN
   logic              par_q;
`endif
   logic [DATA_W-1:0] sr_sh;
   logic              accept;

   assign sr_sh  = sr_q >> 1;
   // The last clock of STOP also takes a word so back-to-back frames
   // leave no gap on the wire.
   assign up.in_ready = ~rst_i & ((state_q == IDLE) ||
                                  ((state_q == STOP) && (div_q == DIV_LAST)));
   assign accept   = up.in_valid & up.in_ready;
   assign tx_i_o   = tx_i_q;
   assign tx_oen_o = tx_oen_q;
   assign busy_o   = (state_q != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         tx_oen_q <= 1'b1;
         tx_i_q   <= 1'b1;
         div_q    <= '0;
         bit_q    <= '0;
      end else if (state_q == IDLE) begin
         if (accept) begin
            sr_q     <= up.in_data;
`ifdef ELVDS_TX_PARITY_EN
            par_q    <= ^up.in_data;
`endif
            div_q    <= '0;
            bit_q    <= '0;
            tx_oen_q <= 1'b0;
            if (PREAMBLE_BITS > 0) begin
               state_q <= PRE;
               tx_i_q  <= 1'b1;
            end else begin
               state_q <= START;
               tx_i_q  <= 1'b0;
            end
         end
      end else if (div_q != DIV_LAST) begin
         div_q <= div_q + 1'b1;
      end else begin
         div_q <= '0;
         case (state_q)
            PRE: begin
               if (bit_q == PRE_LAST) begin
                  bit_q   <= '0;
                  state_q <= START;
                  tx_i_q  <= 1'b0;
               end else begin
                  // preamble bit k is 1 for even k: next value is k[0]
                  bit_q  <= bit_q + 1'b1;
                  tx_i_q <= bit_q[0];
               end
            end
            START: begin
               bit_q   <= '0;
               state_q <= DATA;
               tx_i_q  <= sr_q[0];
            end
            DATA: begin
               if (bit_q == DAT_LAST) begin
                  bit_q   <= '0;
`ifdef ELVDS_TX_PARITY_EN
                  state_q <= PAR;
                  tx_i_q  <= par_q;
`else
                  state_q <= STOP;
                  tx_i_q  <= 1'b1;
`endif
               end else begin
                  bit_q  <= bit_q + 1'b1;
                  sr_q   <= sr_sh;
                  tx_i_q <= sr_sh[0];
               end
            end
`ifdef ELVDS_TX_PARITY_EN
            PAR: begin
               state_q <= STOP;
               tx_i_q  <= 1'b1;
            end
`endif
            STOP: begin
               if (accept) begin
                  // follow-on word: straight to START, no preamble
                  sr_q    <= up.in_data;
`ifdef ELVDS_TX_PARITY_EN
                  par_q   <= ^up.in_data;
`endif
                  bit_q   <= '0;
                  state_q <= START;
                  tx_i_q  <= 1'b0;
               end else begin
                  state_q  <= IDLE;
                  tx_oen_q <= 1'b1;
                  tx_i_q   <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               tx_oen_q <= 1'b1;
               tx_i_q   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_elvds_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_elvds_tx_framer
//  Directed bench for elvds_tx_framer. DUT a uses default parameters,
//  DUT b uses DIV=1 and no preamble. Both share the handshake inputs; only
//  the selected DUT is observed. Expected wire streams come from a small
//  frame model (bit list expanded by DIV). Honours ELVDS_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_elvds_tx_framer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d   = 8'h00;
   logic       v   = 1'b0;
   logic       sel = 1'b0;

   logic tx_a, oen_a, busy_a, tx_b, oen_b, busy_b;
   logic o_txi, o_oen, o_busy, o_rdy;

   int n_tests = 0;
   int n_fail  = 0;

   elvds_tx_framer_if #(.DATA_W(8)) if_a ();
   elvds_tx_framer_if #(.DATA_W(8)) if_b ();

   assign if_a.in_data  = d;
   assign if_a.in_valid = v;
   assign if_b.in_data  = d;
   assign if_b.in_valid = v;

   elvds_tx_framer #(.DATA_W(8), .DIV(4), .PREAMBLE_BITS(2)) dut_a (
      .clk_i(clk), .rst_i(rst), .up(if_a.slave),
      .tx_i_o(tx_a), .tx_oen_o(oen_a), .busy_o(busy_a));

   elvds_tx_framer #(.DATA_W(8), .DIV(1), .PREAMBLE_BITS(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .up(if_b.slave),
      .tx_i_o(tx_b), .tx_oen_o(oen_b), .busy_o(busy_b));

   assign o_txi  = sel ? tx_b  : tx_a;
   assign o_oen  = sel ? oen_b : oen_a;
   assign o_busy = sel ? busy_b : busy_a;
   assign o_rdy  = sel ? if_b.in_ready : if_a.in_ready;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // model
   bit         exp_q[$];
   logic [7:0] words_q[$];
   logic       cap [0:511];
   int         len, ready_hi, busy_lo, first_len;
   int         acc_pos[$];
   bit         timed_out;

   task automatic add_frame(input logic [7:0] w, input int npre, input int div);
      bit b[$];
      for (int k = 0; k < npre; k++) b.push_back((k % 2) == 0);
      b.push_back(1'b0);
      for (int k = 0; k < 8; k++) b.push_back(w[k]);
`ifdef ELVDS_TX_PARITY_EN
      b.push_back(^w);
`endif
      b.push_back(1'b1);
      foreach (b[i]) for (int r = 0; r < div; r++) exp_q.push_back(b[i]);
   endtask

   // Offers words_q on the handshake and records the wire from first drive
   // until tx_oen returns high. Toggle mode scrambles in_data after the
   // first acceptance and withdraws in_valid once in_ready rises.
   task automatic send(input bit toggle);
      int  n, idx;
      bit  started, acc, done;
      n = words_q.size(); idx = 0; len = 0; started = 0; done = 0;
      ready_hi = 0; busy_lo = 0; acc_pos.delete();
      @(negedge clk);
      d = words_q[0]; v = 1'b1;
      for (int it = 0; it < 400 && !done; it++) begin
         if (toggle && idx >= 1 && o_rdy) v = 1'b0;
         acc = v && o_rdy;
         if (acc) acc_pos.push_back(len);
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx < n) d = words_q[idx];
            else if (!toggle) v = 1'b0;
         end
         if (toggle && idx >= 1) d = ~d;
         if (o_oen == 1'b0) begin
            started = 1;
            if (len < 512) cap[len] = o_txi;
            len++;
            if (o_rdy) ready_hi++;
            if (!o_busy) busy_lo++;
         end else if (started) begin
            done = 1;
         end
      end
      v = 1'b0;
      timed_out = !done;
   endtask

   task automatic verify(input string name, input int nframes);
      chk({name, "_timeout"}, {31'd0, timed_out}, 32'd0);
      chk({name, "_len"}, len, exp_q.size());
      for (int i = 0; i < len && i < exp_q.size() && i < 512; i++)
         chk($sformatf("%s_c%0d", name, i), {31'd0, cap[i]}, {31'd0, exp_q[i]});
      chk({name, "_accepts"}, acc_pos.size(), nframes);
      chk({name, "_ready_in_frame"}, ready_hi, nframes);
      chk({name, "_busy_low_in_frame"}, busy_lo, 0);
      chk({name, "_oen_after"}, {31'd0, o_oen}, 32'd1);
      chk({name, "_busy_after"}, {31'd0, o_busy}, 32'd0);
      chk({name, "_ready_after"}, {31'd0, o_rdy}, 32'd1);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_oen", {31'd0, oen_a}, 32'd1);
      chk("rst_txi", {31'd0, tx_a}, 32'd1);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_ready", {31'd0, if_a.in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_ready", {31'd0, if_a.in_ready}, 32'd1);

      // single 0xA5 frame (48 clocks, 52 with parity)
      sel = 1'b0;
      exp_q.delete(); words_q = '{8'hA5};
      add_frame(8'hA5, 2, 4);
      send(1'b0);
      verify("a5", 1);

      // 0x07 after idle: parity bit 1 when enabled
      repeat (5) @(negedge clk);
      exp_q.delete(); words_q = '{8'h07};
      add_frame(8'h07, 2, 4);
      send(1'b0);
      verify("w07", 1);

      // back-to-back: second accept in last STOP clock, no preamble
      repeat (5) @(negedge clk);
      exp_q.delete(); words_q = '{8'h01, 8'hFF};
      add_frame(8'h01, 2, 4);
      first_len = exp_q.size();
      add_frame(8'hFF, 0, 4);
      send(1'b0);
      verify("b2b", 2);
      if (acc_pos.size() == 2) chk("b2b_accept_at", acc_pos[1], first_len);

      // reset during DATA bit 3 (clocks 24..27 of the frame)
      repeat (20) @(negedge clk);
      @(negedge clk); d = 8'hC3; v = 1'b1;
      @(negedge clk); v = 1'b0;
      repeat (25) @(negedge clk);
      chk("mid_oen_driving", {31'd0, oen_a}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_oen", {31'd0, oen_a}, 32'd1);
      chk("abort_txi", {31'd0, tx_a}, 32'd1);
      chk("abort_ready", {31'd0, if_a.in_ready}, 32'd0);
      chk("abort_busy", {31'd0, busy_a}, 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_ready_rel", {31'd0, if_a.in_ready}, 32'd1);
      exp_q.delete(); words_q = '{8'h3C};
      add_frame(8'h3C, 2, 4);
      send(1'b0);
      verify("w3c", 1);

      // in_data scrambled after acceptance
      repeat (5) @(negedge clk);
      exp_q.delete(); words_q = '{8'h5A};
      add_frame(8'h5A, 2, 4);
      send(1'b1);
      verify("tog5a", 1);

      // DIV=1, no preamble, 0x00 (10 clocks)
      repeat (20) @(negedge clk);
      sel = 1'b1;
      #1;
      exp_q.delete(); words_q = '{8'h00};
      add_frame(8'h00, 0, 1);
      send(1'b0);
      verify("div1", 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
